// File: rtl/wb_data_serializer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | wb_data_serializer_pkg                                           |
// | Shared Wishbone constants and bridge FSM state encodings.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package wb_data_serializer_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/wb_data_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | wb_data_serializer                                               |
// | 32-bit Wishbone master to 8-bit slave bridge, one byte per sel.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_data_serializer
  import wb_data_serializer_pkg::*;
#(
  parameter int aw  = 32,
  parameter int mdw = 32,
  parameter int sdw = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [aw-1:0]      wbm_adr_i,
  input  logic [mdw-1:0]     wbm_dat_i,
  input  logic [mdw/8-1:0]   wbm_sel_i,
  input  logic               wbm_we_i,
  input  logic               wbm_cyc_i,
  input  logic               wbm_stb_i,
  input  logic [2:0]         wbm_cti_i,
  input  logic [1:0]         wbm_bte_i,
  output logic [mdw-1:0]     wbm_dat_o,
  output logic               wbm_ack_o,
  output logic               wbm_err_o,
  output logic               wbm_rty_o,
  output logic [aw-1:0]      wbs_adr_o,
  output logic [sdw-1:0]     wbs_dat_o,
  output logic               wbs_we_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  output logic [2:0]         wbs_cti_o,
  output logic [1:0]         wbs_bte_o,
  input  logic [sdw-1:0]     wbs_dat_i,
  input  logic               wbs_ack_i,
  input  logic               wbs_err_i,
  input  logic               wbs_rty_i
);

  state_e           state_q, state_d;
  logic [aw-3:0]    adr_q, adr_d;
  logic             we_q, we_d;
  logic [mdw-1:0]   dat_q, dat_d;
  logic [3:0]       mask_q, mask_d;
  logic [mdw-1:0]   asm_q, asm_d;
  logic [aw-1:0]    wbs_adr_q, wbs_adr_d;
  logic [sdw-1:0]   wbs_dat_q, wbs_dat_d;
  logic             wbs_we_q, wbs_we_d;
  logic             wbs_cyc_q, wbs_cyc_d;
  logic [mdw-1:0]   wbm_dat_q, wbm_dat_d;
  logic             wbm_ack_q, wbm_ack_d;
  logic             wbm_err_q, wbm_err_d;
  logic             wbm_rty_q, wbm_rty_d;

  logic [1:0]       cur_lane;
  logic [1:0]       nxt_lane;
  logic             issue;
  logic             unused_inputs;

  // Highest set bit wins, so byte address 0 (sel[3]) goes out first.
  function automatic logic [1:0] lane_of(input logic [3:0] m);
    lane_of = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) lane_of = 2'(i);
    end
  endfunction

  assign cur_lane      = lane_of(mask_q);
  assign unused_inputs = ^{wbm_adr_i[1:0], wbm_cti_i, wbm_bte_i};

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    we_d      = we_q;
    dat_d     = dat_q;
    mask_d    = mask_q;
    asm_d     = asm_q;
    wbm_dat_d = '0;
    wbm_ack_d = 1'b0;
    wbm_err_d = 1'b0;
    wbm_rty_d = 1'b0;
    issue     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_d  = wbm_adr_i[aw-1:2];
          we_d   = wbm_we_i;
          dat_d  = wbm_dat_i;
          mask_d = wbm_sel_i;
          asm_d  = '0;
          if (wbm_sel_i == 4'b0000) begin
            state_d   = ST_DONE;
            wbm_ack_d = 1'b1;
          end else begin
            state_d = ST_BUS;
            issue   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // Master abort takes precedence over any slave response this cycle.
        if (!wbm_cyc_i) begin
          state_d = ST_IDLE;
          mask_d  = 4'b0000;
        end else if (wbs_err_i || wbs_rty_i) begin
          state_d   = ST_FAIL;
          mask_d    = 4'b0000;
          wbm_err_d = wbs_err_i;
          wbm_rty_d = !wbs_err_i;
        end else if (wbs_ack_i) begin
          if (!we_q) asm_d[{cur_lane, 3'b000} +: sdw] = wbs_dat_i;
          mask_d = mask_q & ~(4'b0001 << cur_lane);
          if (mask_d == 4'b0000) begin
            state_d   = ST_DONE;
            wbm_ack_d = 1'b1;
            wbm_dat_d = asm_d;
          end else begin
            issue = 1'b1;
          end
        end else begin
          issue = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    nxt_lane  = lane_of(mask_d);
    wbs_cyc_d = issue;
    wbs_we_d  = issue ? we_d : 1'b0;
    wbs_adr_d = issue ? {adr_d, 2'd3 - nxt_lane} : '0;
    wbs_dat_d = issue ? dat_d[{nxt_lane, 3'b000} +: sdw] : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      mask_q    <= 4'b0000;
      asm_q     <= '0;
      wbs_adr_q <= '0;
      wbs_dat_q <= '0;
      wbs_we_q  <= 1'b0;
      wbs_cyc_q <= 1'b0;
      wbm_dat_q <= '0;
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
      wbm_rty_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
      mask_q    <= mask_d;
      asm_q     <= asm_d;
      wbs_adr_q <= wbs_adr_d;
      wbs_dat_q <= wbs_dat_d;
      wbs_we_q  <= wbs_we_d;
      wbs_cyc_q <= wbs_cyc_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_ack_q <= wbm_ack_d;
      wbm_err_q <= wbm_err_d;
      wbm_rty_q <= wbm_rty_d;
    end
  end

  assign wbm_dat_o = wbm_dat_q;
  assign wbm_ack_o = wbm_ack_q;
  assign wbm_err_o = wbm_err_q;
  assign wbm_rty_o = wbm_rty_q;
  assign wbs_adr_o = wbs_adr_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_we_o  = wbs_we_q;
  assign wbs_cyc_o = wbs_cyc_q;
  assign wbs_stb_o = wbs_cyc_q;
  assign wbs_cti_o = CTI_CLASSIC;
  assign wbs_bte_o = BTE_LINEAR;

endmodule
`default_nettype wire
